mc_controller: RTL and testbench

Multicycle control unit for the tinymips core. It sequences the shared `alu` (PC increment, branch target, address generation, execute and compare all use one ALU) and the register file, memory and PC enables. A Moore FSM drives the datapath selects and `alu_control`; a handshake stalls the FSM on memory. The block sits between the instruction register and the datapath.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/alu_decoder.sv | 27 ++
 rtl/mc_controller.sv | 132 +++++++++++++
 tb/tb_mc_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared tinymips opcodes, funct codes, ALU encodings and controller state types.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;
    typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNCT} alu_class_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the state's ALU class and funct to alu_control; flags supported functs.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_class_t  i_class,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_control,
    output logic        o_funct_ok
);
    logic [2:0] w_fn_ctl;

    always_comb begin
        w_fn_ctl   = ALU_ADD;
        o_funct_ok = 1'b1;
        case (i_funct)
            FN_ADD:  w_fn_ctl = ALU_ADD;
            FN_SUB:  w_fn_ctl = ALU_SUB;
            FN_AND:  w_fn_ctl = ALU_AND;
            FN_OR:   w_fn_ctl = ALU_OR;
            FN_SLT:  w_fn_ctl = ALU_SLT;
            default: o_funct_ok = 1'b0;
        endcase
    end

    assign o_alu_control = i_class == AC_FUNCT ? w_fn_ctl :
                           i_class == AC_SUB   ? ALU_SUB  : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle Moore control FSM for tinymips; stalls on memory via mem_ready.
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       iord,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal
);
    state_t     r_state, w_next;
    alu_class_t w_class;
    logic       w_funct_ok, w_legal, w_pc_write, w_branch;
    logic       w_ir_write, w_reg_write, w_mem_write, w_illegal;

    alu_decoder u_alu_decoder (
        .i_class       (w_class),
        .i_funct       (funct),
        .o_alu_control (alu_control),
        .o_funct_ok    (w_funct_ok)
    );

    assign w_legal = (op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J ||
                      op == OP_RTYPE) && (op != OP_RTYPE || w_funct_ok);

    always_ff @(posedge clk) r_state <= reset ? S_FETCH : w_next;

    always_comb begin
        w_next      = r_state;
        w_class     = AC_ADD;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        iord        = 1'b0;
        alu_srca    = 1'b0;
        alu_srcb    = 2'b00;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        case (r_state)
            S_FETCH: begin
                alu_srcb   = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_srcb  = 2'b11;
                w_illegal = !w_legal;
                w_next    = !w_legal                       ? S_FETCH   :
                            (op == OP_LW || op == OP_SW)   ? S_MEMADR  :
                            op == OP_RTYPE                 ? S_EXECUTE :
                            op == OP_BEQ                   ? S_BRANCH  :
                            op == OP_ADDI                  ? S_ADDIEX  : S_JUMP;
            end
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                w_next   = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                alu_srca = 1'b1;
                w_class  = AC_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                w_class  = AC_SUB;
                pc_src   = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_srca = 1'b1;
                alu_srcb = 2'b10;
                w_next   = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset suppresses every write so an abandoned instruction leaves no trace.
    assign pc_en     = !reset && (w_pc_write || (w_branch && zero));
    assign ir_write  = !reset && w_ir_write;
    assign reg_write = !reset && w_reg_write;
    assign mem_write = !reset && w_mem_write;
    assign illegal   = !reset && w_illegal;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-cycle scoreboard of expected outputs built from instruction-level rules.
module tb_mc_controller;
    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_en, ir_write, reg_write, mem_write, iord, alu_srca, reg_dst, mem_to_reg, illegal;
    logic [1:0] alu_srcb, pc_src;
    logic [2:0] alu_control;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .iord(iord), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_en, ir_write, reg_write, mem_write, iord, alu_srca;
        logic [1:0] alu_srcb;
        logic reg_dst, mem_to_reg;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic illegal;
    } out_t;
    typedef struct packed {
        logic rst;
        logic [5:0] op, funct;
        logic zero, mr;
        out_t e;
    } cyc_t;

    cyc_t plan[$];
    out_t q_exp[$];
    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_ill = 0, n_rw = 0, n_ir = 0, n_pc = 0, n_slt = 0, run = 0, max_run = 0;
    logic [5:0] c_op, c_funct;
    logic c_zero;

    function automatic out_t dflt();
        out_t e = '0;
        e.alu_control = 3'b010;
        return e;
    endfunction

    function automatic logic fn_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic logic [2:0] fn_ctl(input logic [5:0] f);
        return f == 6'b100010 ? 3'b110 : f == 6'b100100 ? 3'b000 :
               f == 6'b100101 ? 3'b001 : f == 6'b101010 ? 3'b111 : 3'b010;
    endfunction

    task automatic push(input logic r, input logic mr, input out_t e);
        cyc_t c;
        c.rst = r; c.op = c_op; c.funct = c_funct; c.zero = c_zero; c.mr = mr; c.e = e;
        plan.push_back(c);
    endtask

    task automatic fetch(input int stalls);
        out_t e = dflt();
        e.alu_srcb = 2'b01;
        repeat (stalls) push(1'b0, 1'b0, e);
        e.pc_en = 1'b1; e.ir_write = 1'b1;
        push(1'b0, 1'b1, e);
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int fs, input int ms);
        out_t e;
        logic legal;
        c_op = o; c_funct = f; c_zero = z;
        fetch(fs);
        legal = (o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b001000 ||
                 o == 6'b000010 || o == 6'b000000) && (o != 6'b000000 || fn_ok(f));
        e = dflt(); e.alu_srcb = 2'b11; e.illegal = !legal;
        push(1'b0, 1'b0, e);
        if (!legal) begin
        end else if (o == 6'b100011 || o == 6'b101011) begin
            e = dflt(); e.alu_srca = 1'b1; e.alu_srcb = 2'b10;
            push(1'b0, 1'b0, e);
            e = dflt(); e.iord = 1'b1; e.mem_write = (o == 6'b101011);
            repeat (ms) push(1'b0, 1'b0, e);
            push(1'b0, 1'b1, e);
            if (o == 6'b100011) begin
                e = dflt(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                push(1'b0, 1'b0, e);
            end
        end else if (o == 6'b000000) begin
            e = dflt(); e.alu_srca = 1'b1; e.alu_control = fn_ctl(f);
            push(1'b0, 1'b0, e);
            e = dflt(); e.reg_dst = 1'b1; e.reg_write = 1'b1;
            push(1'b0, 1'b0, e);
        end else if (o == 6'b000100) begin
            e = dflt(); e.alu_srca = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
            push(1'b0, 1'b0, e);
        end else if (o == 6'b001000) begin
            e = dflt(); e.alu_srca = 1'b1; e.alu_srcb = 2'b10;
            push(1'b0, 1'b0, e);
            e = dflt(); e.reg_write = 1'b1;
            push(1'b0, 1'b0, e);
        end else begin
            e = dflt(); e.pc_src = 2'b10; e.pc_en = 1'b1;
            push(1'b0, 1'b0, e);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        out_t a, x;
        if (q_exp.size() != 0) begin
            x = q_exp.pop_front();
            a = {pc_en, ir_write, reg_write, mem_write, iord, alu_srca, alu_srcb, reg_dst,
                 mem_to_reg, pc_src, alu_control, illegal};
            n_tests++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL cycle%0d outputs got %h want %h", cyc, a, x);
            end
            n_ill += int'(a.illegal);
            n_rw  += int'(a.reg_write);
            n_ir  += int'(a.ir_write);
            n_pc  += int'(a.pc_en);
            n_slt += int'(a.alu_control == 3'b111);
            run = a.mem_write ? run + 1 : 0;
            if (run > max_run) max_run = run;
            cyc++;
        end
    end

    initial begin
        out_t e;
        c_op = 6'b000000; c_funct = 6'b100000; c_zero = 1'b0;
        e = dflt(); e.alu_srcb = 2'b01;
        push(1'b1, 1'b1, e);
        // R-type add interrupted by a 2-cycle reset while its write-back is pending
        fetch(0);
        e = dflt(); e.alu_srcb = 2'b11;
        push(1'b0, 1'b0, e);
        e = dflt(); e.alu_srca = 1'b1;
        push(1'b0, 1'b0, e);
        e = dflt(); e.reg_dst = 1'b1;
        push(1'b1, 1'b1, e);
        e = dflt(); e.alu_srcb = 2'b01;
        push(1'b1, 1'b1, e);
        instr(6'b100011, 6'b000000, 1'b0, 1, 0);
        instr(6'b101011, 6'b000000, 1'b0, 0, 3);
        instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        instr(6'b000000, 6'b100100, 1'b0, 0, 0);
        instr(6'b000000, 6'b100101, 1'b0, 0, 0);
        instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        instr(6'b100011, 6'b000000, 1'b0, 0, 2);
        instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        instr(6'b000010, 6'b000000, 1'b1, 0, 0);
        instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        instr(6'b000000, 6'b000111, 1'b0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < plan.size(); i++) begin
            #1;
            reset = plan[i].rst; op = plan[i].op; funct = plan[i].funct;
            zero = plan[i].zero; mem_ready = plan[i].mr;
            q_exp.push_back(plan[i].e);
            @(posedge clk);
        end
        #1;
        check("illegal_pulses", n_ill, 2);
        check("sw_mem_write_run", max_run, 4);
        check("reg_write_cycles", n_rw, 7);
        check("ir_write_cycles", n_ir, 14);
        check("pc_en_cycles", n_pc, 16);
        check("slt_cycles", n_slt, 1);
        check("cycles_checked", cyc, plan.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
